data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port. Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. Performs little-endian byte/half/word writes, or reads with sign or zero extension, then returns the result over a second valid/ready handshake. It sits behind the core's data-memory initiator and replaces the single-cycle data memory when multi-cycle memory latency must be modelled.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's data-memory initiator and a responder:
// request channel and response channel, each with its own valid/ready pair.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request at a time, WAIT_CYCLES wait states,
// little-endian byte/half/word access with sign or zero extension on loads.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    rdy_q;
    logic                    vld_q;
    logic [31:0]             rdata_q;
    logic                    error_q;

    logic                    write_q;
    logic                    unsigned_q;
    logic                    err_q;
    logic [1:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;

    logic                    req_err_d;
    logic [ADDR_WIDTH-1:0]   addr1_d;
    logic [ADDR_WIDTH-1:0]   addr2_d;
    logic [ADDR_WIDTH-1:0]   addr3_d;
    logic [31:0]             raw_d;

    logic [7:0]              mem [DEPTH];

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        req_err_d = 1'b0;
        case (bus.req_size)
            2'b01:   req_err_d = bus.req_addr[0];
            2'b10:   req_err_d = |bus.req_addr[1:0];
            2'b11:   req_err_d = 1'b1;
            default: req_err_d = 1'b0;
        endcase
        if ((bus.req_addr >> ADDR_WIDTH) != 32'd0)
            req_err_d = 1'b1;
    end

    // Accesses are naturally aligned, so the +1..+3 byte lanes never wrap for legal requests.
    assign addr1_d = addr_q + ADDR_WIDTH'(1);
    assign addr2_d = addr_q + ADDR_WIDTH'(2);
    assign addr3_d = addr_q + ADDR_WIDTH'(3);
    assign raw_d   = {mem[addr3_d], mem[addr2_d], mem[addr1_d], mem[addr_q]};

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.req_valid) begin
            write_q    <= bus.req_write;
            addr_q     <= bus.req_addr[ADDR_WIDTH-1:0];
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            wdata_q    <= bus.req_wdata;
            err_q      <= req_err_d;
        end
    end

    // Errors still pass through ACCESS (without touching memory) so their response lands one cycle after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        rdy_q <= 1'b0;
                        if (req_err_d || WAIT_CYCLES == 0) begin
                            state_q <= S_ACCESS;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_q <= S_ACCESS;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_ACCESS: begin
                    state_q <= S_RESP;
                    vld_q   <= 1'b1;
                    error_q <= err_q;
                    rdata_q <= (err_q || write_q) ? 32'd0 : load_extend(raw_d, size_q, unsigned_q);
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reset forces state_q out of ACCESS immediately, so an interrupted store never lands.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && write_q && !err_q) begin
            mem[addr_q] <= wdata_q[7:0];
            if (size_q != 2'b00)
                mem[addr1_d] <= wdata_q[15:8];
            if (size_q == 2'b10) begin
                mem[addr2_d] <= wdata_q[23:16];
                mem[addr3_d] <= wdata_q[31:24];
            end
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states,
// one with none for the back-to-back throughput scenario.
module tb_data_mem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] expd;
    } vec_t;

    data_mem_responder_if if2();
    data_mem_responder_if if0();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the two-wait-state instance; lat counts edges from accept to rsp_valid.
    task automatic do_req2(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wd, input logic ack,
                           output int lat, output logic [31:0] rd, output logic er);
        int n;
        if2.req_write    = wr;
        if2.req_addr     = addr;
        if2.req_size     = size;
        if2.req_unsigned = uns;
        if2.req_wdata    = wd;
        if2.req_valid    = 1'b1;
        if2.rsp_ready    = ack;
        n = 0;
        while (!if2.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        if2.req_addr  = 32'h0000_0010;
        if2.req_size  = ~size;
        if2.req_wdata = ~wd;
        if2.req_write = ~wr;
        lat = 0;
        while (!if2.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = if2.rsp_rdata;
        er = if2.rsp_error;
        if (ack && if2.rsp_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive0(input vec_t t);
        if0.req_write    = t.wr;
        if0.req_addr     = t.addr;
        if0.req_size     = t.size;
        if0.req_unsigned = t.uns;
        if0.req_wdata    = t.wd;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (if2.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready actual=%b expected=1", if2.req_ready); end
        checks++; if (if2.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid actual=%b expected=0", if2.rsp_valid); end
        checks++; if (if2.rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rsp_rdata actual=%h expected=0", if2.rsp_rdata); end
        checks++; if (if2.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error actual=%b expected=0", if2.rsp_error); end
        checks++; if (if0.req_ready !== 1'b1) begin failures++; $display("FAIL reset0_req_ready actual=%b expected=1", if0.req_ready); end
        checks++; if (if0.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset0_rsp_valid actual=%b expected=0", if0.rsp_valid); end
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er;
        do_req2(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b1, lat, rd, er);
        checks++; if (lat !== 3) begin failures++; $display("FAIL sw_latency actual=%0d expected=3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw_rsp actual=%b/%h expected=0/00000000", er, rd); end
        do_req2(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (lat !== 3) begin failures++; $display("FAIL lw_latency actual=%0d expected=3", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rsp actual=%b/%h expected=0/deadbeef", er, rd); end
    endtask

    task automatic test_extend();
        int lat; logic [31:0] rd; logic er;
        vec_t v [8] = '{
            '{1'b0, 32'h13, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE},
            '{1'b0, 32'h13, 2'b00, 1'b1, 32'h0,        32'h000000DE},
            '{1'b0, 32'h10, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF},
            '{1'b0, 32'h12, 2'b01, 1'b1, 32'h0,        32'h0000DEAD},
            '{1'b0, 32'h10, 2'b00, 1'b0, 32'h0,        32'hFFFFFFEF},
            '{1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA55, 32'h00000000},
            '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDEAD55EF},
            '{1'b0, 32'h11, 2'b00, 1'b0, 32'h0,        32'h00000055}
        };
        for (int i = 0; i < 8; i++) begin
            do_req2(v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, 1'b1, lat, rd, er);
            checks++;
            if (lat !== 3 || er !== 1'b0 || rd !== v[i].expd) begin
                failures++;
                $display("FAIL extend_%0d actual=lat%0d/err%b/%h expected=lat3/err0/%h", i, lat, er, rd, v[i].expd);
            end
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        vec_t v [6] = '{
            '{1'b0, 32'h00000011, 2'b01, 1'b0, 32'h0,        32'h0},
            '{1'b1, 32'h00000012, 2'b10, 1'b0, 32'hCAFEBABE, 32'h0},
            '{1'b1, 32'h00000010, 2'b11, 1'b0, 32'h11223344, 32'h0},
            '{1'b0, 32'h00000400, 2'b10, 1'b0, 32'h0,        32'h0},
            '{1'b1, 32'h00000400, 2'b10, 1'b0, 32'h99999999, 32'h0},
            '{1'b1, 32'h7FFF0010, 2'b10, 1'b0, 32'h0BADF00D, 32'h0}
        };
        for (int i = 0; i < 6; i++) begin
            do_req2(v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, 1'b1, lat, rd, er);
            checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'd0) begin
                failures++;
                $display("FAIL error_%0d actual=lat%0d/err%b/%h expected=lat1/err1/00000000", i, lat, er, rd);
            end
        end
        do_req2(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) begin failures++; $display("FAIL error_mem_intact actual=%b/%h expected=0/dead55ef", er, rd); end
        do_req2(1'b1, 32'h3FC, 2'b10, 1'b0, 32'hA5A50F0F, 1'b1, lat, rd, er);
        checks++; if (lat !== 3 || er !== 1'b0) begin failures++; $display("FAIL top_word_store actual=lat%0d/err%b expected=lat3/err0", lat, er); end
        do_req2(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (er !== 1'b0 || rd !== 32'hA5A50F0F) begin failures++; $display("FAIL top_word_load actual=%b/%h expected=0/a5a50f0f", er, rd); end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er;
        do_req2(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, lat, rd, er);
        checks++; if (lat !== 3 || rd !== 32'hDEAD55EF) begin failures++; $display("FAIL bp_first actual=lat%0d/%h expected=lat3/dead55ef", lat, rd); end
        if2.req_write = 1'b1; if2.req_addr = 32'h10; if2.req_size = 2'b10; if2.req_wdata = 32'h0BADF00D;
        if2.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if2.rsp_valid !== 1'b1 || if2.rsp_rdata !== 32'hDEAD55EF || if2.req_ready !== 1'b0 || if2.rsp_error !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d actual=v%b/r%b/e%b/%h expected=v1/r0/e0/dead55ef", i, if2.rsp_valid, if2.req_ready, if2.rsp_error, if2.rsp_rdata);
            end
        end
        if2.req_valid = 1'b0;
        if2.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release actual=r%b/v%b expected=r1/v0", if2.req_ready, if2.rsp_valid); end
        do_req2(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL bp_ignored_req actual=%h expected=dead55ef", rd); end
    endtask

    task automatic test_reset_midtxn();
        int lat; logic [31:0] rd; logic er;
        do_req2(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        do_req2(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (rd !== 32'hDEAD55EF) begin failures++; $display("FAIL rst_preload actual=%h expected=dead55ef", rd); end
        if2.req_write = 1'b1; if2.req_addr = 32'h20; if2.req_size = 2'b10; if2.req_unsigned = 1'b0;
        if2.req_wdata = 32'h12345678;
        if2.req_valid = 1'b1;
        @(posedge clk); #1;
        if2.req_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        checks++; if (if2.req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_req_ready actual=%b expected=1", if2.req_ready); end
        checks++; if (if2.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_rsp_valid actual=%b expected=0", if2.rsp_valid); end
        checks++; if (if2.rsp_rdata !== 32'd0) begin failures++; $display("FAIL rst_mid_rsp_rdata actual=%h expected=0", if2.rsp_rdata); end
        checks++; if (if2.rsp_error !== 1'b0) begin failures++; $display("FAIL rst_mid_rsp_error actual=%b expected=0", if2.rsp_error); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        do_req2(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, lat, rd, er);
        checks++; if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL rst_store_dropped actual=lat%0d/err%b/%h expected=lat3/err0/00000000", lat, er, rd); end
    endtask

    task automatic test_back_to_back();
        vec_t v [6] = '{
            '{1'b1, 32'h40, 2'b10, 1'b0, 32'h01020304, 32'h00000000},
            '{1'b0, 32'h40, 2'b10, 1'b0, 32'h0,        32'h01020304},
            '{1'b1, 32'h44, 2'b01, 1'b0, 32'hFFFF8001, 32'h00000000},
            '{1'b0, 32'h44, 2'b01, 1'b0, 32'h0,        32'hFFFF8001},
            '{1'b1, 32'h46, 2'b00, 1'b0, 32'h0000007F, 32'h00000000},
            '{1'b0, 32'h46, 2'b00, 1'b0, 32'h0,        32'h0000007F}
        };
        int   acc_cyc [6];
        int   ai, ri, cyc;
        logic acc;
        ai = 0; ri = 0; cyc = 0;
        if0.rsp_ready = 1'b1;
        drive0(v[0]);
        if0.req_valid = 1'b1;
        while (ri < 6 && cyc < 60) begin
            acc = if0.req_ready && if0.req_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc[ai] = cyc;
                ai++;
                if (ai < 6) drive0(v[ai]);
                else        if0.req_valid = 1'b0;
            end
            if (if0.rsp_valid) begin
                checks++;
                if (if0.rsp_rdata !== v[ri].expd || if0.rsp_error !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data_%0d actual=%b/%h expected=0/%h", ri, if0.rsp_error, if0.rsp_rdata, v[ri].expd);
                end
                checks++;
                if (ri >= ai || cyc - acc_cyc[ri] != 1) begin
                    failures++;
                    $display("FAIL b2b_latency_%0d actual_cycle=%0d accepted=%0d expected_latency=1", ri, cyc, ai);
                end
                ri++;
            end
        end
        checks++;
        if (ri != 6 || ai != 6) begin
            failures++;
            $display("FAIL b2b_timeout actual=%0d/%0d expected=6/6", ai, ri);
        end
        for (int i = 1; i < ai; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                failures++;
                $display("FAIL b2b_spacing_%0d actual=%0d expected=3", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        if0.req_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        if2.req_valid = 1'b0; if2.req_write = 1'b0; if2.req_addr = 32'h0; if2.req_size = 2'b00;
        if2.req_unsigned = 1'b0; if2.req_wdata = 32'h0; if2.rsp_ready = 1'b0;
        if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = 32'h0; if0.req_size = 2'b00;
        if0.req_unsigned = 1'b0; if0.req_wdata = 32'h0; if0.rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_extend();
        test_errors();
        test_backpressure();
        test_reset_midtxn();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
